uart_rx_capture: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_capture.sv | 146 ++++++++++++++
 tb/tb_uart_rx_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clock cycles per serial bit, truncated.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq_hz,
                                             input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with valid/ready pop side; a push while full and not popping is dropped
// and flagged with a one-cycle overflow pulse.
module uart_rx_fifo #(
  parameter int unsigned depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [depth];
  logic [7:0]  mem_d [depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        empty, full, pop, push_ok;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && i_ready;
  assign push_ok = i_push && (!full || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = i_push && full && !pop;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_push_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_data     = mem_q[rd_ptr_q[AW-1:0]];
  assign o_valid    = !empty;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizer, bit-timing FSM and shift register feeding a byte FIFO.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | half a bit into the start bit, confirm it is still low
// DATA      | sample 8 data bits, LSB first, one per bit time
// STOP      | sample the stop bit; high pushes the byte, low flags a frame error
// WAIT_HIGH | after a frame error, hold until the line returns high
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 32'd50_000_000,
  parameter int unsigned baud_rate   = 115200,
  parameter int unsigned fifo_depth  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int unsigned BIT  = bit_cycles(clk_freq_hz, baud_rate);
  localparam int unsigned HALF = BIT / 2;
  localparam int unsigned CW   = $clog2(BIT);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          rx_meta_q, rx_s_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          push;

  // Down-counter is loaded with period-1 so a phase lasts exactly period cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = BIT_LOAD;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = BIT_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  uart_rx_fifo #(
    .depth(fifo_depth)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (push),
    .i_push_data(shift_q),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed plus randomized frames against a byte-level reference model of the receiver.
module tb_uart_rx_capture;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  // Non-idle cycles from entering START to the stop-bit sample.
  localparam int FRAME_BUSY = HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overflow, o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int ferr_seen = 0, ovf_seen = 0;
  int valid_rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic [7:0] got_q[$];

  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovf = 0;
  int m_occ = 0;
  logic m_ready = 1'b0;
  int t_start = 0;
  int k;

  uart_rx_capture dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_frame_err) ferr_seen <= ferr_seen + 1;
      if (o_overflow) ovf_seen <= ovf_seen + 1;
      if (o_valid && !valid_prev) valid_rise_cyc <= cyc;
      valid_prev <= o_valid;
    end else begin
      valid_prev <= 1'b0;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: what a correct receiver delivers, frame by frame.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (m_ready || m_occ < DEPTH) begin
      exp_q.push_back(b);
      if (!m_ready) m_occ++;
    end else exp_ovf++;
  endtask

  task automatic drive_bit(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    logic [7:0] d;
    d = b;
    t_start = cyc;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (stop_low_bits > 0) drive_bit(1'b0, stop_low_bits * BIT);
    drive_bit(1'b1, BIT);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 i_ready = v;
    m_ready = v;
    if (v) m_occ = 0;
    @(negedge clk);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    chk({tag, "_ferr"}, ferr_seen, exp_ferr);
    chk({tag, "_ovf"}, ovf_seen, exp_ovf);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_data, o_valid, o_frame_err, o_overflow, o_busy}, 32'h0);
    rst = 1'b0;
    set_ready(1'b1);

    // Single frame and its latency from the start edge
    send_frame(8'h41, 0);
    model_frame(8'h41, 1'b1);
    chk("latency_window", (valid_rise_cyc - t_start >= (BIT * 19) / 2 - 8) &&
                          (valid_rise_cyc - t_start <= (BIT * 19) / 2 + 8), 1'b1);
    compare_q("single");

    // Short low glitch is rejected
    drive_bit(1'b0, 4);
    drive_bit(1'b1, HALF + 20);
    chk("glitch_busy", o_busy, 1'b0);
    compare_q("glitch");

    // Break-length stop: exactly one frame error, then a clean frame
    send_frame(8'h55, 3);
    model_frame(8'h55, 1'b0);
    chk("ferr_fifo_empty", got_q.size(), 0);
    send_frame(8'hA5, 0);
    model_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    compare_q("frame_err");

    // Overflow with consumer stalled
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0);
      model_frame(8'(i), 1'b1);
    end
    repeat (4) @(negedge clk);
    chk("ovf_pulses", ovf_seen, exp_ovf);
    chk("ovf_valid", o_valid, 1'b1);
    chk("ovf_head", o_data, 8'h01);
    chk("ovf_no_pop", got_q.size(), 0);
    set_ready(1'b1);
    repeat (8) @(negedge clk);
    compare_q("overflow");

    // Full FIFO with a pop in the same cycle as the fifth push
    set_ready(1'b0);
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 0);
      model_frame(8'(i), 1'b1);
    end
    m_occ--;
    model_frame(8'h05, 1'b1);
    fork
      send_frame(8'h05, 0);
      begin
        for (k = 0; k < 3 * BIT && !o_busy; k++) @(negedge clk);
        chk("fullpop_busy_seen", o_busy, 1'b1);
        repeat (FRAME_BUSY - 1) @(posedge clk);
        #1 i_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_busy_before", o_busy, 1'b1);
        chk("fullpop_head", o_data, 8'h01);
        @(negedge clk);
        chk("fullpop_busy_after", o_busy, 1'b0);
        chk("fullpop_no_ovf", o_overflow, 1'b0);
      end
    join
    m_ready = 1'b1;
    m_occ = 0;
    repeat (8) @(negedge clk);
    compare_q("full_pop");

    // Reset in the middle of the data bits of 0xFF
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, 3 * BIT);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_outputs", {o_data, o_valid, o_frame_err, o_overflow, o_busy}, 32'h0);
    end
    rst = 1'b0;
    drive_bit(1'b1, 6 * BIT - 3);
    chk("midreset_idle", o_busy, 1'b0);
    send_frame(8'h3C, 0);
    model_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    compare_q("mid_reset");

    // Random bytes, random gaps, occasional low stop bit
    for (int i = 0; i < 2; i++) begin
      logic [7:0] b;
      logic good;
      b = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      drive_bit(1'b1, $urandom_range(0, 40));
      send_frame(b, good ? 0 : 1);
      model_frame(b, good);
    end
    repeat (4) @(negedge clk);
    compare_q("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
